mips_multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences a multicycle MIPS datapath with shared instruction/data memory.

---
 rtl/mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore control FSM for a multicycle MIPS datapath that shares one memory
// between instructions and data. It decodes op/funct from the instruction
// register and drives every datapath select and enable, including the memory
// read/write strobes.
//
// Parameters
//   SUPPORT_BNE  1: opcode 000101 executes as bne; 0: treated as illegal
//   SUPPORT_J    1: opcode 000010 executes as j;   0: treated as illegal
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, funct         instr[31:26] / instr[5:0] from the IR
//   zero              ALU zero flag (meaningful in the branch states)
//   pc_en             PC load enable (combinational, includes branch resolve)
//   iord              memory address select: 0 = PC, 1 = ALUOut
//   mem_read/write    memory strobes
//   ir_write          IR load enable
//   reg_dst           write register select: 0 = rt, 1 = rd
//   mem_to_reg        write-back select: 0 = ALUOut, 1 = MDR
//   reg_write         register file write enable
//   alu_src_a         ALU A select: 0 = PC, 1 = A
//   alu_src_b         ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_control       010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_src            00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op        pulse in DECODE for an unsupported opcode
//   instr_done        pulse in the last state of every instruction
//   state             current state encoding (debug)
//
// While reset is high every output, pc_en and mem_write included, is held
// at 0 combinationally, so a reset landing mid-instruction never lets a
// store or PC update through.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter bit SUPPORT_BNE = 1'b1,
    parameter bit SUPPORT_J   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11,
        S_BNEEX  = 4'd12
    } state_t;

    state_t state_q, state_d;

    // Opcode dispatch out of DECODE; op_legal feeds the illegal_op pulse.
    state_t     decode_target;
    logic       op_legal;
    logic [2:0] funct_alu;

    always_comb begin
        decode_target = S_FETCH;
        op_legal      = 1'b1;
        case (op)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_R:         decode_target = S_RTEX;
            OP_BEQ:       decode_target = S_BEQEX;
            OP_ADDI:      decode_target = S_ADDIEX;
            OP_BNE: begin
                if (SUPPORT_BNE) decode_target = S_BNEEX;
                else             op_legal      = 1'b0;
            end
            OP_J: begin
                if (SUPPORT_J) decode_target = S_JEX;
                else           op_legal      = 1'b0;
            end
            default:      op_legal = 1'b0;
        endcase
    end

    // Unknown funct codes quietly fall back to add.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = decode_target;
            // Only lw and sw reach MEMADR, so op picks between the two.
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_RTEX:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Moore output decode from the current state, before reset gating.
    logic       pc_write_raw, branch_raw, branch_ne_raw;
    logic       iord_raw, mem_read_raw, mem_write_raw, ir_write_raw;
    logic       reg_dst_raw, mem_to_reg_raw, reg_write_raw, alu_src_a_raw;
    logic [1:0] alu_src_b_raw, pc_src_raw;
    logic [2:0] alu_control_raw;
    logic       illegal_raw, done_raw;

    always_comb begin
        pc_write_raw    = 1'b0;
        branch_raw      = 1'b0;
        branch_ne_raw   = 1'b0;
        iord_raw        = 1'b0;
        mem_read_raw    = 1'b0;
        mem_write_raw   = 1'b0;
        ir_write_raw    = 1'b0;
        reg_dst_raw     = 1'b0;
        mem_to_reg_raw  = 1'b0;
        reg_write_raw   = 1'b0;
        alu_src_a_raw   = 1'b0;
        alu_src_b_raw   = 2'b00;
        alu_control_raw = ALU_ADD;
        pc_src_raw      = 2'b00;
        illegal_raw     = 1'b0;
        done_raw        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw  = 1'b1;
                ir_write_raw  = 1'b1;
                pc_write_raw  = 1'b1;
                alu_src_b_raw = 2'b01;
            end
            S_DECODE: begin
                // Branch target precomputed here into ALUOut.
                alu_src_b_raw = 2'b11;
                illegal_raw   = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            S_MEMRD: begin
                iord_raw     = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw  = 1'b1;
                mem_to_reg_raw = 1'b1;
                done_raw       = 1'b1;
            end
            S_MEMWR: begin
                iord_raw      = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a_raw   = 1'b1;
                alu_control_raw = funct_alu;
            end
            S_RTWB: begin
                reg_write_raw = 1'b1;
                reg_dst_raw   = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alu_src_a_raw   = 1'b1;
                alu_control_raw = ALU_SUB;
                pc_src_raw      = 2'b01;
                branch_raw      = (state_q == S_BEQEX);
                branch_ne_raw   = (state_q == S_BNEEX);
                done_raw        = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_JEX: begin
                pc_src_raw   = 2'b10;
                pc_write_raw = 1'b1;
                done_raw     = 1'b1;
            end
            // Encodings 13-15: everything off, including the ALU op.
            default: alu_control_raw = 3'b000;
        endcase
    end

    // Branch resolution happens in the same cycle through zero.
    assign pc_en       = ~reset & (pc_write_raw | (branch_raw & zero) | (branch_ne_raw & ~zero));
    assign iord        = ~reset & iord_raw;
    assign mem_read    = ~reset & mem_read_raw;
    assign mem_write   = ~reset & mem_write_raw;
    assign ir_write    = ~reset & ir_write_raw;
    assign reg_dst     = ~reset & reg_dst_raw;
    assign mem_to_reg  = ~reset & mem_to_reg_raw;
    assign reg_write   = ~reset & reg_write_raw;
    assign alu_src_a   = ~reset & alu_src_a_raw;
    assign alu_src_b   = reset ? 2'b00  : alu_src_b_raw;
    assign alu_control = reset ? 3'b000 : alu_control_raw;
    assign pc_src      = reset ? 2'b00  : pc_src_raw;
    assign illegal_op  = ~reset & illegal_raw;
    assign instr_done  = ~reset & done_raw;
    assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for mips_multicycle_ctrl. Two instances share the stimulus: one with
// default parameters and one with bne/j disabled. A path-based model predicts
// the state walk of each instance and a per-state rule set predicts the
// outputs; the compare process checks both instances every cycle. Directed
// instruction runs also record traces that are pinned to hand-written values.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst;
    logic       a_mem_to_reg, a_reg_write, a_alu_src_a, a_illegal_op, a_instr_done;
    logic [1:0] a_alu_src_b, a_pc_src;
    logic [2:0] a_alu_control;
    logic [3:0] a_state;

    logic       b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst;
    logic       b_mem_to_reg, b_reg_write, b_alu_src_a, b_illegal_op, b_instr_done;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [2:0] b_alu_control;
    logic [3:0] b_state;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_control(a_alu_control), .pc_src(a_pc_src), .illegal_op(a_illegal_op),
        .instr_done(a_instr_done), .state(a_state)
    );

    mips_multicycle_ctrl #(.SUPPORT_BNE(1'b0), .SUPPORT_J(1'b0)) dut_n (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_control(b_alu_control), .pc_src(b_pc_src), .illegal_op(b_illegal_op),
        .instr_done(b_instr_done), .state(b_state)
    );

    always #5 clk = ~clk;

    wire [21:0] a_vec = {a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst,
                         a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_control,
                         a_pc_src, a_illegal_op, a_instr_done, a_state};
    wire [21:0] b_vec = {b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst,
                         b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_control,
                         b_pc_src, b_illegal_op, b_instr_done, b_state};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit op_ok(input logic [5:0] o, input bit bok, input bit jok);
        return (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000}) ||
               (o == 6'b000101 && bok) || (o == 6'b000010 && jok);
    endfunction

    // Each instruction is FETCH, DECODE, then a fixed path of states
    // (packed as nibbles, first step in the low nibble), then back to FETCH.
    function automatic void path_of(input logic [5:0] o, input bit bok, input bit jok,
                                    output int p, output int n);
        p = 0; n = 0;
        if (op_ok(o, bok, jok)) begin
            case (o)
                6'b100011: begin p = 'h432; n = 3; end
                6'b101011: begin p = 'h52;  n = 2; end
                6'b000000: begin p = 'h76;  n = 2; end
                6'b000100: begin p = 'h8;   n = 1; end
                6'b000101: begin p = 'hC;   n = 1; end
                6'b001000: begin p = 'hA9;  n = 2; end
                default:   begin p = 'hB;   n = 1; end
            endcase
        end
    endfunction

    int m_state[2], m_path[2], m_len[2], m_pos[2];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p, n, pos;
            if (reset) begin
                m_state[i] <= 0; m_len[i] <= 0; m_pos[i] <= 0;
            end else if (m_state[i] == 0) begin
                m_state[i] <= 1;
            end else begin
                p = m_path[i]; n = m_len[i]; pos = m_pos[i];
                if (m_state[i] == 1) begin
                    path_of(op, i == 0, i == 0, p, n);
                    pos = 0;
                end
                if (pos < n) begin
                    m_state[i] <= (p >> (4 * pos)) & 15;
                    pos++;
                end else begin
                    m_state[i] <= 0;
                end
                m_path[i] <= p; m_len[i] <= n; m_pos[i] <= pos;
            end
        end
        m_valid <= 1'b1;
    end

    function automatic logic [21:0] exp_vec(input int st, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input logic rst, input bit bok, input bit jok);
        logic pcw, br, brn, pce, ill, done;
        logic [1:0] srcb, psrc;
        logic [2:0] alu;
        if (rst) return '0;
        pcw  = st inside {0, 11};
        br   = (st == 8);
        brn  = (st == 12);
        pce  = pcw | (br & z) | (brn & ~z);
        srcb = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st inside {2, 9}) ? 2'b10 : 2'b00;
        psrc = (br | brn) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
        alu  = 3'b010;
        if (br | brn) alu = 3'b110;
        if (st == 6) begin
            case (f)
                6'b100010: alu = 3'b110;
                6'b100100: alu = 3'b000;
                6'b100101: alu = 3'b001;
                6'b101010: alu = 3'b111;
                default:   alu = 3'b010;
            endcase
        end
        ill  = (st == 1) && !op_ok(o, bok, jok);
        done = st inside {4, 5, 7, 8, 10, 11, 12};
        return {pce, logic'(st inside {3, 5}), logic'(st inside {0, 3}), logic'(st == 5),
                logic'(st == 0), logic'(st == 7), logic'(st == 4), logic'(st inside {4, 7, 10}),
                logic'(st inside {2, 6, 8, 9, 12}), srcb, alu, psrc, ill, done, 4'(st)};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_default", {10'd0, a_vec}, {10'd0, exp_vec(m_state[0], op, funct, zero, reset, 1'b1, 1'b1)});
            chk("cycle_nobne_noj", {10'd0, b_vec}, {10'd0, exp_vec(m_state[1], op, funct, zero, reset, 1'b0, 1'b0)});
        end
    end

    // ---------------- directed runs ----------------
    logic [31:0] tr_states;
    logic [7:0]  tr_pcen, tr_iord, tr_mr, tr_mw, tr_irw, tr_wb, tr_rd, tr_m2r, tr_done, tr_ill, tr_ill_n;
    logic [2:0]  tr_alu [8];
    logic [1:0]  tr_psrc [8];

    // Called #1 after a posedge with the default instance in FETCH; returns
    // #1 after the edge that brings it back to FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
        tr_states = '0; tr_pcen = '0; tr_iord = '0; tr_mr = '0; tr_mw = '0; tr_irw = '0;
        tr_wb = '0; tr_rd = '0; tr_m2r = '0; tr_done = '0; tr_ill = '0; tr_ill_n = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tr_states[4*c +: 4] = a_state;
            tr_pcen[c] = a_pc_en;   tr_iord[c] = a_iord;     tr_mr[c] = a_mem_read;
            tr_mw[c]   = a_mem_write; tr_irw[c] = a_ir_write; tr_wb[c] = a_reg_write;
            tr_rd[c]   = a_reg_dst; tr_m2r[c] = a_mem_to_reg; tr_done[c] = a_instr_done;
            tr_ill[c]  = a_illegal_op; tr_ill_n[c] = b_illegal_op;
            tr_alu[c]  = a_alu_control; tr_psrc[c] = a_pc_src;
            @(posedge clk); #1;
            if (m_state[0] == 0) return;
        end
        chk("instr_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(2);

        // lw straight out of reset
        run_instr(6'b100011, 6'd0, 1'b0);
        chk("reset_fetch_strobes", {tr_mr[0], tr_irw[0], tr_pcen[0], tr_mw[0]}, 4'b1110);
        chk("lw_states", tr_states, 32'h0004_3210);
        chk("lw_iord", tr_iord, 8'h08);
        chk("lw_memread", tr_mr, 8'h09);
        chk("lw_wb", {tr_wb, tr_m2r}, {8'h10, 8'h10});
        chk("lw_done", tr_done, 8'h10);

        run_instr(6'b101011, 6'd0, 1'b0);
        chk("sw_states", tr_states, 32'h0000_5210);
        chk("sw_memwrite", tr_mw, 8'h08);

        run_instr(6'b000000, 6'b101010, 1'b0);
        chk("r_states", tr_states, 32'h0000_7610);
        chk("r_slt_alu", {29'd0, tr_alu[2]}, 32'd7);
        chk("r_wb", {tr_rd, tr_wb}, {8'h08, 8'h08});
        run_instr(6'b000000, 6'b100010, 1'b0);
        chk("r_sub_alu", {29'd0, tr_alu[2]}, 32'd6);
        run_instr(6'b000000, 6'b111111, 1'b0);
        chk("r_unknown_alu", {29'd0, tr_alu[2]}, 32'd2);

        run_instr(6'b000100, 6'd0, 1'b1);
        chk("beq_taken", {tr_states, tr_pcen}, {32'h0000_0810, 8'h05});
        chk("beq_pcsrc", {30'd0, tr_psrc[2]}, 32'd1);
        run_instr(6'b000100, 6'd0, 1'b0);
        chk("beq_not_taken", tr_pcen, 8'h01);

        run_instr(6'b001000, 6'd0, 1'b0);
        chk("addi_states", {tr_states, tr_wb, tr_done}, {32'h0000_A910, 8'h08, 8'h08});

        run_instr(6'b111111, 6'd0, 1'b0);
        chk("illegal", {tr_states, tr_ill}, {32'h0000_0010, 8'h02});

        // bne/j desynchronise the restricted instance, so resync after each
        run_instr(6'b000101, 6'd0, 1'b1);
        chk("bne_z1", {tr_states, tr_pcen}, {32'h0000_0C10, 8'h01});
        chk("bne_disabled_illegal", tr_ill_n, 8'h02);
        do_reset(1);
        run_instr(6'b000101, 6'd0, 1'b0);
        chk("bne_z0", tr_pcen, 8'h05);
        do_reset(1);
        run_instr(6'b000010, 6'd0, 1'b0);
        chk("j_states", {tr_states, tr_pcen}, {32'h0000_0B10, 8'h05});
        chk("j_pcsrc", {30'd0, tr_psrc[2]}, 32'd2);
        chk("j_disabled_illegal", tr_ill_n, 8'h02);
        do_reset(1);

        // sw interrupted by reset while in MEMWR
        op = 6'b101011; funct = 6'd0; zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("sw_reached_memwr", m_state[0], 5);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_memwr", {a_mem_write, a_pc_en, a_iord, a_state}, 7'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'd0, 1'b0);
        chk("after_reset_lw", tr_states, 32'h0004_3210);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
